dac_ad5544_frame_rx: RTL and testbench

// - SPI receiver for the AD5544 write protocol: CS/SCLK/SDIN/LDAC/RS/MSB, 18-bit frames {addr[1:0], data[15:0]}, MSB first.
// - Oversamples the serial pins on the system clock and mirrors the DAC's two register banks:
//   - four input registers, written by frames;
//   - four DAC registers, loaded from the input registers on an LDAC falling edge.
// - Sits in the board-test and loopback path opposite the AD5544 driver.
// - Reports each decoded frame and counts malformed frames.

---
 rtl/dac_ad5544_frame_rx_if.sv | 18 +
 rtl/dac_ad5544_frame_rx.sv | 169 ++++++++++++++++
 tb/tb_dac_ad5544_frame_rx.sv | 308 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dac_ad5544_frame_rx_if.sv
// AD5544 serial write bus: chip select, serial clock/data, load strobe,
// register reset and reset-value select. The master drives, the receiver listens.
interface dac_ad5544_frame_rx_if;
  logic SPI_CS;
  logic SPI_SCLK;
  logic SPI_SDIN;
  logic SPI_LDAC;
  logic SPI_RS;
  logic SPI_MSB;

  modport master (
    output SPI_CS, SPI_SCLK, SPI_SDIN, SPI_LDAC, SPI_RS, SPI_MSB
  );

  modport slave (
    input SPI_CS, SPI_SCLK, SPI_SDIN, SPI_LDAC, SPI_RS, SPI_MSB
  );
endinterface

// File: rtl/dac_ad5544_frame_rx.sv
// AD5544 write-protocol receiver: oversamples the serial pins, decodes
// {addr[1:0], data} frames into four input registers and mirrors the DAC
// registers that load from them on an LDAC falling edge.
module dac_ad5544_frame_rx #(
  parameter int DATA_W = 16,
  parameter int ERR_W  = 8
) (
  input  logic              clk,
  input  logic              reset,
  dac_ad5544_frame_rx_if.slave spi,
  output logic [DATA_W-1:0] DAC_OUT1,
  output logic [DATA_W-1:0] DAC_OUT2,
  output logic [DATA_W-1:0] DAC_OUT3,
  output logic [DATA_W-1:0] DAC_OUT4,
  output logic              FRAME_VALID,
  output logic [1:0]        FRAME_ADDR,
  output logic [DATA_W-1:0] FRAME_DATA,
  output logic              FRAME_ERR,
  output logic [ERR_W-1:0]  ERR_CNT,
  output logic              BUSY
);

  localparam int         FRAME_W   = DATA_W + 2;
  localparam logic [4:0] FRAME_LEN = 5'(FRAME_W);

  typedef enum logic [1:0] {IDLE, SHIFT, CHECK} state_t;

  state_t state, next_state;

  // synchroniser stages: {cs, sclk, sdin, ldac, rs, msb}
  logic [5:0] pin_s1, pin_s2;
  logic       cs_d, sclk_d, ldac_d;
  logic       cs, sclk, sdin, ldac, rs_n, msb;
  logic       cs_rise, cs_fall, sclk_rise, ldac_fall;

  logic [FRAME_W-1:0] shift_reg;
  logic [4:0]         bit_cnt;
  logic               from_check;

  logic        shift_en, frame_start, commit_good, commit_bad;
  logic [1:0]  wr_addr;
  logic [DATA_W-1:0] wr_data, rs_val;

  logic [DATA_W-1:0] in_reg  [4];
  logic [DATA_W-1:0] dac_reg [4];

  // Pin synchronisers and edge-detect stage. Deliberately not reset: they
  // keep tracking the pins through reset, so release never fakes an edge.
  always_ff @(posedge clk) begin
    pin_s1 <= {spi.SPI_CS, spi.SPI_SCLK, spi.SPI_SDIN,
               spi.SPI_LDAC, spi.SPI_RS, spi.SPI_MSB};
    pin_s2 <= pin_s1;
    cs_d   <= pin_s2[5];
    sclk_d <= pin_s2[4];
    ldac_d <= pin_s2[2];
  end

  assign cs   = pin_s2[5];
  assign sclk = pin_s2[4];
  assign sdin = pin_s2[3];
  assign ldac = pin_s2[2];
  assign rs_n = pin_s2[1];
  assign msb  = pin_s2[0];

  assign cs_rise   = cs & ~cs_d;
  assign cs_fall   = ~cs & cs_d;
  assign sclk_rise = sclk & ~sclk_d;
  assign ldac_fall = ~ldac & ldac_d;

  // State register.
  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else        state <= next_state;
  end

  // Next-state logic. A CS fall seen during CHECK has already passed the
  // edge detector by the IDLE cycle, so IDLE also accepts a low CS level
  // when it was entered straight from CHECK.
  always_comb begin
    next_state = state;
    unique case (state)
      IDLE:    if (cs_fall || (from_check && !cs)) next_state = SHIFT;
      SHIFT:   if (cs_rise) next_state = CHECK;
      CHECK:   next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Per-state control strobes.
  always_comb begin
    frame_start = 1'b0;
    shift_en    = 1'b0;
    commit_good = 1'b0;
    commit_bad  = 1'b0;
    unique case (state)
      IDLE:    frame_start = (next_state == SHIFT);
      SHIFT:   shift_en    = sclk_rise && !cs;
      CHECK: begin
        commit_good = (bit_cnt == FRAME_LEN);
        commit_bad  = (bit_cnt != FRAME_LEN);
      end
      default: ;
    endcase
  end

  assign wr_addr = shift_reg[FRAME_W-1 -: 2];
  assign wr_data = shift_reg[DATA_W-1:0];
  assign rs_val  = msb ? {1'b1, {(DATA_W-1){1'b0}}} : '0;

  // Shift register, bit counter and frame report outputs.
  always_ff @(posedge clk) begin
    if (!reset) begin
      shift_reg   <= '0;
      bit_cnt     <= '0;
      from_check  <= 1'b0;
      FRAME_VALID <= 1'b0;
      FRAME_ERR   <= 1'b0;
      FRAME_ADDR  <= '0;
      FRAME_DATA  <= '0;
      ERR_CNT     <= '0;
    end else begin
      from_check  <= (state == CHECK);
      FRAME_VALID <= commit_good;
      FRAME_ERR   <= commit_bad;
      if (frame_start) begin
        shift_reg <= '0;
        bit_cnt   <= '0;
      end else if (shift_en) begin
        shift_reg <= {shift_reg[FRAME_W-2:0], sdin};
        if (bit_cnt != '1) bit_cnt <= bit_cnt + 5'd1;
      end
      if (commit_good) begin
        FRAME_ADDR <= wr_addr;
        FRAME_DATA <= wr_data;
      end
      if (commit_bad && ERR_CNT != '1) ERR_CNT <= ERR_CNT + 1'b1;
    end
  end

  // Input and DAC register banks. RS dominates; otherwise a commit writes
  // its input register and an LDAC fall copies all input registers, taking
  // the freshly committed word for that channel in the same cycle.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int unsigned i = 0; i < 4; i++) begin
        in_reg[i]  <= '0;
        dac_reg[i] <= '0;
      end
    end else if (!rs_n) begin
      for (int unsigned i = 0; i < 4; i++) begin
        in_reg[i]  <= rs_val;
        dac_reg[i] <= rs_val;
      end
    end else begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (commit_good && wr_addr == 2'(i)) in_reg[i] <= wr_data;
        if (ldac_fall)
          dac_reg[i] <= (commit_good && wr_addr == 2'(i)) ? wr_data : in_reg[i];
      end
    end
  end

  assign DAC_OUT1 = dac_reg[0];
  assign DAC_OUT2 = dac_reg[1];
  assign DAC_OUT3 = dac_reg[2];
  assign DAC_OUT4 = dac_reg[3];
  assign BUSY     = (state == SHIFT);

endmodule

// File: tb/tb_dac_ad5544_frame_rx.sv
// Bench for dac_ad5544_frame_rx: directed scenarios plus random traffic,
// checked every cycle against a frame-level reference model.
module tb_dac_ad5544_frame_rx;
  localparam int DW = 16;
  localparam int EW = 8;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  dac_ad5544_frame_rx_if bus ();

  logic [DW-1:0] dac1, dac2, dac3, dac4, fdata;
  logic          fv, fe, busy;
  logic [1:0]    faddr;
  logic [EW-1:0] ecnt;

  dac_ad5544_frame_rx #(.DATA_W(DW), .ERR_W(EW)) u_dut (
    .clk(clk), .reset(reset), .spi(bus),
    .DAC_OUT1(dac1), .DAC_OUT2(dac2), .DAC_OUT3(dac3), .DAC_OUT4(dac4),
    .FRAME_VALID(fv), .FRAME_ADDR(faddr), .FRAME_DATA(fdata),
    .FRAME_ERR(fe), .ERR_CNT(ecnt), .BUSY(busy)
  );

  int n_pass = 0;
  int n_total = 0;
  int n_fv = 0;
  int n_fe = 0;
  logic chk_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // ---------------- reference model ----------------
  // Pin effect lands 3 clk edges after the first edge sampling the new
  // level: at edge k the effective level is the sample from edge k-2 and
  // the previous level the sample from edge k-3.
  logic [5:0]  h0 = 6'b100110, h1 = 6'b100110, h2 = 6'b100110;
  logic [15:0] m_in [4];
  logic [15:0] m_dac [4];
  logic [1:0]  m_addr;
  logic [15:0] m_data;
  logic        m_fv, m_fe, m_open, m_chk, m_pend;
  int          m_nbits, m_err;
  logic [17:0] m_bits;

  logic [15:0] t_in [4];
  logic [15:0] t_dac [4];
  logic [5:0]  cur, prv;
  logic        t_fv, t_fe, t_open, t_chk, t_pend;
  logic [1:0]  t_addr;
  logic [15:0] t_data, rsv;
  int          t_err, t_nb;
  logic [17:0] t_bits;

  // model update at each clk edge
  always @(posedge clk) begin
    cur = h1;
    prv = h2;
    if (!reset) begin
      for (int i = 0; i < 4; i++) begin
        m_in[i]  <= '0;
        m_dac[i] <= '0;
      end
      m_addr <= '0; m_data <= '0; m_fv <= 1'b0; m_fe <= 1'b0;
      m_open <= 1'b0; m_chk <= 1'b0; m_pend <= 1'b0;
      m_nbits <= 0; m_err <= 0; m_bits <= '0;
    end else begin
      t_in = m_in; t_dac = m_dac;
      t_fv = 1'b0; t_fe = 1'b0;
      t_addr = m_addr; t_data = m_data; t_err = m_err;
      if (m_chk) begin
        if (m_nbits == DW + 2) begin
          t_fv = 1'b1;
          t_addr = m_bits[17:16];
          t_data = m_bits[15:0];
          t_in[t_addr] = t_data;
        end else begin
          t_fe = 1'b1;
          if (t_err < 255) t_err++;
        end
      end
      rsv = cur[0] ? 16'h8000 : 16'h0000;
      if (!cur[1]) begin
        for (int i = 0; i < 4; i++) begin
          t_in[i] = rsv;
          t_dac[i] = rsv;
        end
      end else if (prv[2] && !cur[2]) begin
        t_dac = t_in;
      end
      t_open = m_open; t_chk = 1'b0; t_pend = m_pend;
      t_nb = m_nbits; t_bits = m_bits;
      if (m_open) begin
        if (cur[4] && !prv[4] && !cur[5]) begin
          t_bits = {t_bits[16:0], cur[3]};
          if (t_nb < 31) t_nb++;
        end
        if (cur[5] && !prv[5]) begin
          t_open = 1'b0;
          t_chk = 1'b1;
        end
      end else if (m_chk) begin
        if (!cur[5] && prv[5]) t_pend = 1'b1;
      end else if ((!cur[5] && prv[5]) || (m_pend && !cur[5])) begin
        t_open = 1'b1; t_nb = 0; t_bits = '0; t_pend = 1'b0;
      end
      m_in <= t_in; m_dac <= t_dac;
      m_fv <= t_fv; m_fe <= t_fe; m_addr <= t_addr; m_data <= t_data;
      m_err <= t_err; m_open <= t_open; m_chk <= t_chk; m_pend <= t_pend;
      m_nbits <= t_nb; m_bits <= t_bits;
    end
    h2 <= h1;
    h1 <= h0;
    h0 <= {bus.SPI_CS, bus.SPI_SCLK, bus.SPI_SDIN, bus.SPI_LDAC, bus.SPI_RS, bus.SPI_MSB};
  end

  // compare DUT against the model every cycle
  always @(negedge clk) begin
    if (chk_en) begin
      check("DAC_OUT1", 32'(dac1), 32'(m_dac[0]));
      check("DAC_OUT2", 32'(dac2), 32'(m_dac[1]));
      check("DAC_OUT3", 32'(dac3), 32'(m_dac[2]));
      check("DAC_OUT4", 32'(dac4), 32'(m_dac[3]));
      check("FRAME_VALID", 32'(fv), 32'(m_fv));
      check("FRAME_ERR", 32'(fe), 32'(m_fe));
      check("FRAME_ADDR", 32'(faddr), 32'(m_addr));
      check("FRAME_DATA", 32'(fdata), 32'(m_data));
      check("ERR_CNT", 32'(ecnt), 32'(m_err));
      check("BUSY", 32'(busy), 32'(m_open));
      if (fv) n_fv++;
      if (fe) n_fe++;
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One CS-framed transfer of nbits bits of val, MSB first. If ldac_lag >= 0
  // an LDAC fall is driven ldac_lag cycles after CS rises.
  task automatic frame(input int nbits, input logic [31:0] val, input int ldac_lag);
    logic [31:0] v;
    v = val;
    bus.SPI_CS = 1'b0;
    tick(3 + $urandom_range(0, 2));
    for (int i = nbits - 1; i >= 0; i--) begin
      bus.SPI_SDIN = v[i];
      bus.SPI_SCLK = 1'b0;
      tick(3 + $urandom_range(0, 2));
      bus.SPI_SCLK = 1'b1;
      tick(3 + $urandom_range(0, 2));
    end
    bus.SPI_SCLK = 1'b0;
    tick(3);
    bus.SPI_CS = 1'b1;
    if (ldac_lag >= 0) begin
      tick(ldac_lag);
      bus.SPI_LDAC = 1'b0;
      tick(4);
      bus.SPI_LDAC = 1'b1;
    end
    tick(8);
  endtask

  task automatic ldac_pulse();
    bus.SPI_LDAC = 1'b0;
    tick(5);
    bus.SPI_LDAC = 1'b1;
    tick(5);
  endtask

  int fv0, fe0, k, nb;
  logic [15:0] expv [4];

  initial begin
    bus.SPI_CS = 1'b1; bus.SPI_SCLK = 1'b0; bus.SPI_SDIN = 1'b0;
    bus.SPI_LDAC = 1'b1; bus.SPI_RS = 1'b1; bus.SPI_MSB = 1'b0;
    tick(6);
    chk_en = 1'b1;
    check("rst_DAC_OUT1", 32'(dac1), 32'h0);
    check("rst_ERR_CNT", 32'(ecnt), 32'h0);
    check("rst_FRAME_VALID", 32'(fv), 32'h0);
    check("rst_BUSY", 32'(busy), 32'h0);
    reset = 1'b1;
    tick(4);

    // single frame to channel 3, then LDAC
    fv0 = n_fv;
    frame(18, {14'h0, 2'h2, 16'hA5C3}, -1);
    check("t1_valid_pulses", 32'(n_fv - fv0), 32'd1);
    check("t1_addr", 32'(faddr), 32'h2);
    check("t1_data", 32'(fdata), 32'hA5C3);
    check("t1_dac3_held", 32'(dac3), 32'h0);
    ldac_pulse();
    check("t1_dac3_loaded", 32'(dac3), 32'hA5C3);

    // four channels, one LDAC: all outputs move on the same edge
    expv[0] = 16'h1111; expv[1] = 16'h2222; expv[2] = 16'h3333; expv[3] = 16'h4444;
    for (int c = 0; c < 4; c++) frame(18, {14'h0, 2'(c), expv[c]}, -1);
    bus.SPI_LDAC = 1'b0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      k = int'(dac1 == 16'h1111) + int'(dac2 == 16'h2222) +
          int'(dac3 == 16'h3333) + int'(dac4 == 16'h4444);
      check("t2_simultaneous", 32'(k == 0 || k == 4), 32'd1);
    end
    bus.SPI_LDAC = 1'b1;
    tick(4);
    check("t2_dac1", 32'(dac1), 32'h1111);
    check("t2_dac4", 32'(dac4), 32'h4444);

    // short and long frames are rejected
    fv0 = n_fv; fe0 = n_fe;
    frame(17, $urandom, -1);
    frame(19, $urandom, -1);
    check("t3_err_pulses", 32'(n_fe - fe0), 32'd2);
    check("t3_err_cnt", 32'(ecnt), 32'd2);
    check("t3_no_valid", 32'(n_fv - fv0), 32'd0);
    ldac_pulse();
    check("t3_dac2_kept", 32'(dac2), 32'h2222);
    check("t3_dac3_kept", 32'(dac3), 32'h3333);

    // register reset to midscale and zero; RS overriding a commit
    bus.SPI_MSB = 1'b1; bus.SPI_RS = 1'b0;
    tick(6);
    check("t4_mid_dac1", 32'(dac1), 32'h8000);
    check("t4_mid_dac4", 32'(dac4), 32'h8000);
    bus.SPI_MSB = 1'b0;
    tick(5);
    check("t4_zero_dac3", 32'(dac3), 32'h0);
    bus.SPI_MSB = 1'b1;
    fv0 = n_fv;
    frame(18, {14'h0, 2'h1, 16'h1234}, 1);
    check("t4_valid_under_rs", 32'(n_fv - fv0), 32'd1);
    check("t4_data_under_rs", 32'(fdata), 32'h1234);
    check("t4_dac2_forced", 32'(dac2), 32'h8000);
    bus.SPI_RS = 1'b1; bus.SPI_MSB = 1'b0;
    tick(4);
    ldac_pulse();
    check("t4_in2_forced", 32'(dac2), 32'h8000);

    // reset in the middle of a frame discards it
    fv0 = n_fv; fe0 = n_fe;
    bus.SPI_CS = 1'b0;
    tick(4);
    for (int i = 0; i < 9; i++) begin
      bus.SPI_SDIN = 1'($urandom);
      bus.SPI_SCLK = 1'b0; tick(3);
      bus.SPI_SCLK = 1'b1; tick(3);
    end
    reset = 1'b0; tick(2); reset = 1'b1; tick(2);
    bus.SPI_SCLK = 1'b0; tick(3);
    bus.SPI_CS = 1'b1;
    tick(8);
    check("t5_no_pulses", 32'((n_fv - fv0) + (n_fe - fe0)), 32'd0);
    frame(18, {14'h0, 2'h0, 16'hBEEF}, -1);
    ldac_pulse();
    check("t5_dac1", 32'(dac1), 32'hBEEF);
    check("t5_err_cleared", 32'(ecnt), 32'h0);

    // error counter saturation
    for (int i = 0; i < 300; i++) frame(1, $urandom, -1);
    check("t6_err_sat", 32'(ecnt), 32'd255);

    // LDAC fall on the commit edge writes through
    frame(18, {14'h0, 2'h1, 16'h5A69}, 1);
    check("t6_dac2_through", 32'(dac2), 32'h5A69);

    // random traffic
    for (int it = 0; it < 60; it++) begin
      case ($urandom_range(0, 9))
        0, 1, 2, 3, 4, 5:
          frame(18, $urandom, ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 3)) : -1);
        6: begin
          nb = $urandom_range(1, 24);
          if (nb == 18) nb = 20;
          frame(nb, $urandom, -1);
        end
        7: ldac_pulse();
        8: begin
          bus.SPI_MSB = 1'($urandom);
          bus.SPI_RS = 1'b0;
          tick($urandom_range(1, 6));
          bus.SPI_RS = 1'b1;
          tick(5);
        end
        default: begin
          for (int i = 0; i < 3; i++) begin
            bus.SPI_SCLK = 1'b1; tick(3);
            bus.SPI_SCLK = 1'b0; tick(3);
          end
          if ($urandom_range(0, 1) == 1) begin
            reset = 1'b0; tick(2); reset = 1'b1; tick(2);
          end
        end
      endcase
    end
    tick(10);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
